// File: rtl/udp_box_collector.sv
// udp_box_collector: assembles box-list UDP payloads into packed records
// and commits them at frame start. Optional trailing checksum: UDP_BOX_CKSUM_EN.
module udp_box_collector #(
  parameter  int N_BOX = 4,
  parameter  int H_ACT = 1280,
  parameter  int V_ACT = 720,
  parameter  int C_DEP = 2,
  localparam int SEG_W = 2 * ($clog2(H_ACT) + $clog2(V_ACT)) + 3 * C_DEP,
  localparam int CW    = $clog2(N_BOX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_last,
  input  logic                   frame_start,
  output logic [N_BOX*SEG_W-1:0] udp_data,
  output logic [CW-1:0]          box_cnt,
  output logic                   update,
  output logic                   pkt_drop
);

  localparam int RB = SEG_W / 8;
  localparam int BW = $clog2(RB + 1);
  localparam int TW = N_BOX * SEG_W;
  localparam logic [7:0] MAGIC = 8'hA5;

  if (SEG_W % 8 != 0) begin : g_seg_chk
    $error("SEG_W must be a multiple of 8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CNT, S_DATA, S_CSUM, S_COMMIT, S_DRAIN
  } state_t;

  state_t        state, state_nx;
  logic          drop_nx, clr, wr, n_ld, fin;
  logic [CW-1:0] n_reg, rec_i, pend_cnt;
  logic [BW-1:0] byte_j;
  logic [7:0]    xsum;
  logic [TW-1:0] asm_buf, pend, pend_nx;
  logic          pend_flag;

  assign fin = (rec_i + CW'(1) == n_reg) && (byte_j == BW'(RB - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    drop_nx  = 1'b0;
    clr      = 1'b0;
    wr       = 1'b0;
    n_ld     = 1'b0;
    if (state == S_COMMIT) state_nx = S_IDLE;
    if (rx_valid) begin
      unique case (state)
        S_IDLE, S_COMMIT: begin
          if (rx_data == MAGIC && !rx_last) begin
            state_nx = S_CNT;
          end else if (rx_last) begin
            drop_nx  = 1'b1;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_DRAIN;
          end
        end
        S_CNT: begin
          n_ld = 1'b1;
          if (rx_data > 8'(N_BOX)) begin
            if (rx_last) begin
              drop_nx  = 1'b1;
              state_nx = S_IDLE;
            end else begin
              state_nx = S_DRAIN;
            end
          end else if (rx_data == 8'h00) begin
`ifdef UDP_BOX_CKSUM_EN
            if (rx_last) begin
              drop_nx  = 1'b1;
              state_nx = S_IDLE;
            end else begin
              clr      = 1'b1;
              state_nx = S_CSUM;
            end
`else
            if (rx_last) state_nx = S_COMMIT;
            else         state_nx = S_DRAIN;
`endif
          end else if (rx_last) begin
            drop_nx  = 1'b1;
            state_nx = S_IDLE;
          end else begin
            clr      = 1'b1;
            state_nx = S_DATA;
          end
        end
        S_DATA: begin
          wr = 1'b1;
          if (fin) begin
`ifdef UDP_BOX_CKSUM_EN
            if (rx_last) begin
              drop_nx  = 1'b1;
              state_nx = S_IDLE;
            end else begin
              state_nx = S_CSUM;
            end
`else
            if (rx_last) state_nx = S_COMMIT;
            else         state_nx = S_DRAIN;
`endif
          end else if (rx_last) begin
            drop_nx  = 1'b1;
            state_nx = S_IDLE;
          end
        end
        S_CSUM: begin
          if (rx_last) begin
            if (rx_data == xsum) begin
              state_nx = S_COMMIT;
            end else begin
              drop_nx  = 1'b1;
              state_nx = S_IDLE;
            end
          end else begin
            state_nx = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rx_last) begin
            drop_nx  = 1'b1;
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Assembly buffer and byte cursor; xsum holds the XOR of all prior bytes.
  always_ff @(posedge clk) begin
    if (clr) asm_buf <= '0;
    if (wr) begin
      for (int s = 0; s < N_BOX; s++) begin
        for (int b = 0; b < RB; b++) begin
          if (rec_i == CW'(s) && byte_j == BW'(b))
            asm_buf[s*SEG_W + (RB-1-b)*8 +: 8] <= rx_data;
        end
      end
    end
    if (clr) begin
      rec_i  <= '0;
      byte_j <= '0;
    end else if (wr) begin
      if (byte_j == BW'(RB - 1)) begin
        byte_j <= '0;
        rec_i  <= rec_i + CW'(1);
      end else begin
        byte_j <= byte_j + BW'(1);
      end
    end
    if (n_ld) n_reg <= rx_data[CW-1:0];
    if (rx_valid) begin
      if (state == S_IDLE || state == S_COMMIT) xsum <= rx_data;
      else                                      xsum <= xsum ^ rx_data;
    end
  end

  always_comb begin
    pend_nx = '0;
    for (int s = 0; s < N_BOX; s++) begin
      if (CW'(s) < n_reg)
        pend_nx[s*SEG_W +: SEG_W] = asm_buf[s*SEG_W +: SEG_W];
    end
  end

  // Commit sets the flag after frame_start has sampled the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      udp_data  <= '0;
      box_cnt   <= '0;
      update    <= 1'b0;
      pkt_drop  <= 1'b0;
      pend_flag <= 1'b0;
      pend      <= '0;
      pend_cnt  <= '0;
    end else begin
      pkt_drop <= drop_nx;
      update   <= frame_start & pend_flag;
      if (frame_start && pend_flag) begin
        udp_data <= pend;
        box_cnt  <= pend_cnt;
      end
      if (state == S_COMMIT) begin
        pend      <= pend_nx;
        pend_cnt  <= n_reg;
        pend_flag <= 1'b1;
      end else if (frame_start) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule
